// File: rtl/beta_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single request/ack memory bus.
// Data requests win over fetches; illegal addresses and ack timeouts fault.
module beta_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 65536,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] InstructionAddress,
  input  logic                  iReq,
  output logic [DATA_WIDTH-1:0] InstructionData,
  output logic                  instructionReady,
  output logic                  iMemfault,
  input  logic [ADDR_WIDTH-1:0] DataAddress,
  input  logic [DATA_WIDTH-1:0] DataWrite,
  input  logic                  ReadEnable,
  input  logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] DataRead,
  output logic                  dataReady,
  output logic                  dMemfault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT  = (ADDR_WIDTH+1)'(MEM_BYTES);
  localparam logic [7:0]          WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t                state;
  logic                  grantD;
  logic                  faultFlag;
  logic [7:0]            waitCnt;

  logic                  dPending;
  logic                  anyReq;
  logic                  isStore;
  logic                  reqLegal;
  logic [ADDR_WIDTH-1:0] reqAddr;

  function automatic logic addrLegal(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < MEM_LIMIT);
  endfunction

  always_comb begin
    dPending = ReadEnable | WriteEnable;
    anyReq   = dPending | iReq;
    isStore  = WriteEnable;
    reqAddr  = dPending ? DataAddress : InstructionAddress;
    reqLegal = addrLegal(reqAddr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      grantD           <= 1'b0;
      faultFlag        <= 1'b0;
      waitCnt          <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      InstructionData  <= '0;
      DataRead         <= '0;
      instructionReady <= 1'b0;
      dataReady        <= 1'b0;
      iMemfault        <= 1'b0;
      dMemfault        <= 1'b0;
    end else begin
      instructionReady <= 1'b0;
      dataReady        <= 1'b0;
      iMemfault        <= 1'b0;
      dMemfault        <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantD  <= dPending;
            waitCnt <= '0;
            if (!reqLegal) begin
              // Illegal address never reaches the memory bus.
              faultFlag        <= 1'b1;
              state            <= DONE;
              instructionReady <= !dPending;
              iMemfault        <= !dPending;
              dataReady        <= dPending;
              dMemfault        <= dPending;
            end else begin
              faultFlag <= 1'b0;
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= dPending && isStore;
              mem_addr  <= reqAddr;
              if (dPending && isStore) mem_wdata <= DataWrite;
            end
          end
        end
        BUSY: begin
          // Ack takes priority so an ack on the last allowed cycle is not a fault.
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            faultFlag <= 1'b0;
            state     <= DONE;
            if (grantD) begin
              dataReady <= 1'b1;
              if (!mem_we) DataRead <= mem_rdata;
            end else begin
              instructionReady <= 1'b1;
              InstructionData  <= mem_rdata;
            end
          end else if (waitCnt == WAIT_LAST) begin
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            faultFlag        <= 1'b1;
            state            <= DONE;
            instructionReady <= !grantD;
            iMemfault        <= !grantD;
            dataReady        <= grantD;
            dMemfault        <= grantD;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        DONE: begin
          waitCnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/beta_mem_arbiter.md
BETA_MEM_ARBITER -- requirements
Module: beta_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte-address width of the core and memory address buses.
REQ-002 Parameter DATA_WIDTH, 32, word width of all data buses.
REQ-003 Parameter MEM_BYTES, 65536, size of the mapped region; byte addresses >= MEM_BYTES fault.
REQ-004 Parameter TIMEOUT, 15, maximum BUSY cycles waiting for mem_ack before a fault is raised; legal range 1..255.
REQ-005 Clock and reset are fixed: one clock, and reset is asynchronous and active-high.
REQ-006 The ports SHALL be as follows (clock and reset first):
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- InstructionAddress  in  ADDR_WIDTH  instruction fetch address
- iReq  in  1  fetch request, held until instructionReady
- InstructionData  out  DATA_WIDTH  fetched word
- instructionReady  out  1  one-cycle fetch completion pulse
- iMemfault  out  1  fetch fault, coincident with instructionReady
- DataAddress  in  ADDR_WIDTH  load/store address
- DataWrite  in  DATA_WIDTH  store data
- ReadEnable  in  1  load request, held until dataReady
- WriteEnable  in  1  store request, held until dataReady
- DataRead  out  DATA_WIDTH  loaded word
- dataReady  out  1  one-cycle load/store completion pulse
- dMemfault  out  1  data fault, coincident with dataReady
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write qualifier
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completion
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack

Function
REQ-007 The FSM SHALL have three states, IDLE, BUSY and DONE; a grant register records the active port (I or D).
REQ-008 In IDLE, a pending data request (ReadEnable|WriteEnable) SHALL win over iReq; iReq is granted only when no data request is pending.
REQ-009 ReadEnable and WriteEnable both high SHALL be treated as a store.
REQ-010 In IDLE with a granted request whose address is misaligned (addr[1:0]!=0) or >= MEM_BYTES, the FSM SHALL go directly to DONE with the fault flag set, and mem_req SHALL never assert.
REQ-011 In IDLE with a legal granted request, the FSM SHALL go to BUSY; mem_req, mem_addr, mem_we and mem_wdata are registered at that edge and held stable throughout BUSY.
REQ-012 In BUSY, mem_ack sampled high SHALL capture mem_rdata (loads and fetches only), drop mem_req, and move to DONE with no fault.
REQ-013 In BUSY, a wait counter SHALL count cycles without mem_ack; when it reaches TIMEOUT, the FSM SHALL drop mem_req and go to DONE with the fault flag set.
REQ-014 A mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL complete normally, not as a fault.
REQ-015 DONE SHALL last exactly one cycle, during which the granted port's Ready is high and its Memfault equals the fault flag; the FSM then returns to IDLE unconditionally.
REQ-016 The IDLE cycle after DONE SHALL let the core drop its request, so a held request is never serviced twice.
REQ-017 InstructionData and DataRead SHALL hold their last captured value until the next capture on the same port; a faulted access leaves them unchanged.
REQ-018 Minimum latency for a legal access is request seen in IDLE at cycle N, mem_ack at N+1, Ready at N+2; a fault with no memory access gives Ready at N+1.
REQ-019 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-020 While rst is high, the FSM SHALL be IDLE and mem_req, mem_we, instructionReady, dataReady, iMemfault, dMemfault, the wait counter and the fault flag SHALL all be 0.
REQ-021 While rst is high, mem_addr, mem_wdata, InstructionData and DataRead SHALL be 0.
REQ-022 An rst assertion during BUSY SHALL abandon the access immediately (mem_req drops asynchronously) and produce no Ready pulse.

Verification
REQ-023 Fetch: iReq=1 at InstructionAddress=0x100, mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> instructionReady pulses one cycle with InstructionData=0xDEADBEEF and iMemfault=0.
REQ-024 Contention: iReq and ReadEnable raised together (0x100 / 0x200) -> mem_addr=0x200 is served first, then an IDLE cycle, then mem_addr=0x100.
REQ-025 Fault: DataAddress=0x202, or 0x10000 with MEM_BYTES=65536 -> dataReady=1 and dMemfault=1 one cycle later, with mem_req never asserting.
REQ-026 Timeout: store with mem_ack held 0 and TIMEOUT=15 -> mem_req high for 15 cycles, then dataReady=1 and dMemfault=1.
REQ-027 Boundary ack: mem_ack arrives on the 15th BUSY cycle -> dMemfault=0.
REQ-028 Reset: rst pulsed during BUSY -> all outputs zero, no Ready pulse, and the next request is serviced normally.
